// File: rtl/commut_adr_seq.sv
// -----------------------------------------------------------------------------
// commut_adr_seq
//
// Commutator address sequencer for the frame-buffer read path. Each strobe
// from the frame timer starts one word cycle: wait WE_DELAY+1 cycles, pulse
// WE for WE_LEN cycles at the current address, then advance the address. The
// address wraps after FRAME_LEN words and raises the frame-complete flag.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous, active-high reset
//   strob  in   asynchronous word strobe (synchronised internally)
//   clr    in   synchronous frame restart, active-high
//   rdAdr  out  current word address [ADR_W-1:0]
//   WE     out  write enable for the word at rdAdr
//   full   out  frame complete (level, held until next word starts or clr)
//   err    out  sticky short-strobe error (strobe fell before WE finished)
// -----------------------------------------------------------------------------
module commut_adr_seq #(
  parameter int ADR_W       = 5,
  parameter int FRAME_LEN   = 20,
  parameter int WE_DELAY    = 13,
  parameter int WE_LEN      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strob,
  input  logic             clr,
  output logic [ADR_W-1:0] rdAdr,
  output logic             WE,
  output logic             full,
  output logic             err
);

  // Parameter legality is enforced at elaboration time.
  if (FRAME_LEN < 2 || FRAME_LEN > (1 << ADR_W)) begin : g_bad_frame_len
    $error("commut_adr_seq: FRAME_LEN must be in 2..2**ADR_W");
  end
  if (WE_DELAY < 0 || WE_DELAY > 255) begin : g_bad_we_delay
    $error("commut_adr_seq: WE_DELAY must be in 0..255");
  end
  if (WE_LEN < 1 || WE_LEN > 255) begin : g_bad_we_len
    $error("commut_adr_seq: WE_LEN must be in 1..255");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("commut_adr_seq: SYNC_STAGES must be at least 2");
  end

  localparam int CNT_W = $clog2(WE_DELAY + WE_LEN + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DELAY    = 2'd1;
  localparam logic [1:0] S_WRITE    = 2'd2;
  localparam logic [1:0] S_WAIT_LOW = 2'd3;

  // The counter runs through DELAY (0..WE_DELAY) and on through WRITE
  // (WE_DELAY+1..WE_DELAY+WE_LEN), so one counter times both phases.
  localparam logic [CNT_W-1:0] CNT_DLY_END = CNT_W'(WE_DELAY);
  localparam logic [CNT_W-1:0] CNT_WR_END  = CNT_W'(WE_DELAY + WE_LEN);
  localparam logic [ADR_W-1:0] LAST_ADR    = ADR_W'(FRAME_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADR_W-1:0]       r_adr;
  logic                   r_we;
  logic                   r_full;
  logic                   r_err;

  logic w_ss;
  logic w_last;

  assign w_ss   = r_sync[SYNC_STAGES-1];
  assign w_last = (r_adr == LAST_ADR);

  // Synchroniser: clr deliberately does not touch it, so a strobe that is
  // still high across a restart is seen as "already served".
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, matching real hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], strob};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_we    <= 1'b0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else if (clr) begin
      // A strobe still high at restart must not launch a new burst.
      r_state <= w_ss ? S_WAIT_LOW : S_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_we    <= 1'b0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // Strobe dropped before its word finished: flag it, but let the
      // word complete normally.
      if ((r_state == S_DELAY || r_state == S_WRITE) && !w_ss) begin
        r_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_ss) begin
            r_state <= S_DELAY;
            r_cnt   <= '0;
            r_full  <= 1'b0;
          end
        end
        S_DELAY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_DLY_END) begin
            r_state <= S_WRITE;
            r_we    <= 1'b1;
          end
        end
        S_WRITE: begin
          if (r_cnt == CNT_WR_END) begin
            r_we    <= 1'b0;
            r_state <= S_WAIT_LOW;
            if (w_last) begin
              r_adr  <= '0;
              r_full <= 1'b1;
            end else begin
              r_adr <= r_adr + ADR_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_LOW: begin
          // Re-arm only after the strobe has been seen low.
          if (!w_ss) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdAdr = r_adr;
  assign WE    = r_we;
  assign full  = r_full;
  assign err   = r_err;

endmodule

// File: tb/tb_commut_adr_seq.sv
// -----------------------------------------------------------------------------
// tb_commut_adr_seq
//
// Two sequencer instances: dut_a with default parameters and dut_b with a
// short frame and minimal WE timing. Each strobe pushes the expected burst
// (address, first WE cycle, next address, full) to a per-instance queue; a
// negedge monitor pops and compares when the DUT raises and drops WE.
// -----------------------------------------------------------------------------
module tb_commut_adr_seq;

  localparam int SYNC  = 2;
  localparam int A_FL  = 20;
  localparam int A_DLY = 13;
  localparam int A_LEN = 2;
  localparam int B_FL  = 4;
  localparam int B_DLY = 0;
  localparam int B_LEN = 1;

  typedef struct {
    int adr;
    int start;
    int nxt;
    int full;
  } exp_t;

  logic       clk;
  logic       a_rst, a_strob, a_clr;
  logic [4:0] a_adr;
  logic       a_we, a_full, a_err;
  logic       b_rst, b_strob, b_clr;
  logic [4:0] b_adr;
  logic       b_we, b_full, b_err;

  int   n_checks;
  int   n_errors;
  int   cyc;
  int   m_adr_a;
  int   m_adr_b;
  exp_t q_a[$];
  exp_t q_b[$];

  commut_adr_seq dut_a (
    .clk   (clk),
    .rst   (a_rst),
    .strob (a_strob),
    .clr   (a_clr),
    .rdAdr (a_adr),
    .WE    (a_we),
    .full  (a_full),
    .err   (a_err)
  );

  commut_adr_seq #(
    .ADR_W       (5),
    .FRAME_LEN   (B_FL),
    .WE_DELAY    (B_DLY),
    .WE_LEN      (B_LEN),
    .SYNC_STAGES (SYNC)
  ) dut_b (
    .clk   (clk),
    .rst   (b_rst),
    .strob (b_strob),
    .clr   (b_clr),
    .rdAdr (b_adr),
    .WE    (b_we),
    .full  (b_full),
    .err   (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called at a negedge: queue the expected burst and raise the strobe.
  task automatic strobe_start(input int which);
    exp_t e;
    if (which == 0) begin
      e.adr   = m_adr_a;
      e.start = cyc + SYNC + A_DLY + 2;
      e.full  = (m_adr_a == A_FL - 1) ? 1 : 0;
      e.nxt   = (m_adr_a == A_FL - 1) ? 0 : m_adr_a + 1;
      m_adr_a = e.nxt;
      q_a.push_back(e);
      a_strob = 1'b1;
    end else begin
      e.adr   = m_adr_b;
      e.start = cyc + SYNC + B_DLY + 2;
      e.full  = (m_adr_b == B_FL - 1) ? 1 : 0;
      e.nxt   = (m_adr_b == B_FL - 1) ? 0 : m_adr_b + 1;
      m_adr_b = e.nxt;
      q_b.push_back(e);
      b_strob = 1'b1;
    end
  endtask

  task automatic strobe(input int which, input int hi, input int lo);
    strobe_start(which);
    repeat (hi) @(negedge clk);
    if (which == 0) a_strob = 1'b0;
    else            b_strob = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Burst monitor, dut_a.
  initial begin
    exp_t cur;
    int   len;
    bit   busy;
    bit   prev;
    busy = 0;
    prev = 0;
    len  = 0;
    forever begin
      @(negedge clk);
      if (a_rst) begin
        busy = 0;
        prev = 0;
      end else begin
        if (a_we && !prev) begin
          check("a_we_expected", 32'(q_a.size() > 0), 32'd1);
          if (q_a.size() > 0) begin
            cur = q_a.pop_front();
            check("a_we_adr", 32'(a_adr), 32'(cur.adr));
            check("a_we_start", 32'(cyc), 32'(cur.start));
            len  = 0;
            busy = 1;
          end
        end
        if (a_we) len++;
        if (!a_we && prev && busy) begin
          check("a_we_len", 32'(len), 32'(A_LEN));
          check("a_adr_next", 32'(a_adr), 32'(cur.nxt));
          check("a_full_after", 32'(a_full), 32'(cur.full));
          busy = 0;
        end
        prev = a_we;
      end
    end
  end

  // Burst monitor, dut_b.
  initial begin
    exp_t cur;
    int   len;
    bit   busy;
    bit   prev;
    busy = 0;
    prev = 0;
    len  = 0;
    forever begin
      @(negedge clk);
      if (b_rst) begin
        busy = 0;
        prev = 0;
      end else begin
        if (b_we && !prev) begin
          check("b_we_expected", 32'(q_b.size() > 0), 32'd1);
          if (q_b.size() > 0) begin
            cur = q_b.pop_front();
            check("b_we_adr", 32'(b_adr), 32'(cur.adr));
            check("b_we_start", 32'(cyc), 32'(cur.start));
            len  = 0;
            busy = 1;
          end
        end
        if (b_we) len++;
        if (!b_we && prev && busy) begin
          check("b_we_len", 32'(len), 32'(B_LEN));
          check("b_adr_next", 32'(b_adr), 32'(cur.nxt));
          check("b_full_after", 32'(b_full), 32'(cur.full));
          busy = 0;
        end
        prev = b_we;
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_adr_a  = 0;
    m_adr_b  = 0;
    a_rst = 1'b1; a_strob = 1'b0; a_clr = 1'b0;
    b_rst = 1'b1; b_strob = 1'b0; b_clr = 1'b0;

    // Reset values.
    #2;
    check("rst_a_adr", 32'(a_adr), 32'd0);
    check("rst_a_we", 32'(a_we), 32'd0);
    check("rst_a_full", 32'(a_full), 32'd0);
    check("rst_a_err", 32'(a_err), 32'd0);
    check("rst_b_adr", 32'(b_adr), 32'd0);
    check("rst_b_we", 32'(b_we), 32'd0);
    repeat (3) @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Words 0..6 (first burst also covers the basic timing and held strobe).
    for (int i = 0; i < 7; i++) strobe(0, 40, 40);

    // Asynchronous reset in the middle of DELAY for word 7.
    strobe_start(0);
    repeat (8) @(negedge clk);
    check("pre_rst_adr", 32'(a_adr), 32'd7);
    #2 a_rst = 1'b1;
    #1;
    check("async_rst_adr", 32'(a_adr), 32'd0);
    check("async_rst_we", 32'(a_we), 32'd0);
    check("async_rst_full", 32'(a_full), 32'd0);
    check("async_rst_err", 32'(a_err), 32'd0);
    a_strob = 1'b0;
    q_a.delete();
    m_adr_a = 0;
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
    repeat (3) @(negedge clk);

    // Full frame of 20 words, then the wrap and full flag.
    for (int i = 0; i < 20; i++) strobe(0, 40, 40);
    check("frame_adr_wrap", 32'(a_adr), 32'd0);
    check("frame_full_held", 32'(a_full), 32'd1);

    // 21st strobe: full stays up while IDLE, drops on DELAY entry.
    strobe_start(0);
    repeat (2) @(negedge clk);
    check("full_before_delay", 32'(a_full), 32'd1);
    @(negedge clk);
    check("full_on_delay", 32'(a_full), 32'd0);
    repeat (37) @(negedge clk);
    a_strob = 1'b0;
    repeat (40) @(negedge clk);

    // Short strobe: err set during DELAY, word still completes.
    strobe_start(0);
    repeat (4) @(negedge clk);
    check("short_err_before", 32'(a_err), 32'd0);
    @(negedge clk);
    a_strob = 1'b0;
    repeat (5) @(negedge clk);
    check("short_err_set", 32'(a_err), 32'd1);
    repeat (30) @(negedge clk);
    strobe(0, 40, 40);
    strobe(0, 40, 40);
    check("err_sticky", 32'(a_err), 32'd1);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    check("clr_err", 32'(a_err), 32'd0);
    check("clr_adr_idle", 32'(a_adr), 32'd0);
    m_adr_a = 0;
    repeat (3) @(negedge clk);

    // Words 0..8, then clr in the second WE cycle of word 9, strobe held.
    for (int i = 0; i < 9; i++) strobe(0, 40, 40);
    strobe_start(0);
    q_a[q_a.size() - 1].nxt = 0;
    m_adr_a = 0;
    repeat (18) @(negedge clk);
    check("clr_pre_we", 32'(a_we), 32'd1);
    check("clr_pre_adr", 32'(a_adr), 32'd9);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    check("clr_we", 32'(a_we), 32'd0);
    check("clr_adr", 32'(a_adr), 32'd0);
    check("clr_full", 32'(a_full), 32'd0);
    repeat (21) @(negedge clk);
    a_strob = 1'b0;
    repeat (40) @(negedge clk);
    strobe(0, 40, 40);
    check("after_clr_adr", 32'(a_adr), 32'd1);

    // Small instance: short frame, zero delay, single-cycle WE.
    for (int i = 0; i < 4; i++) strobe(1, 10, 10);
    check("b_wrap_adr", 32'(b_adr), 32'd0);
    check("b_wrap_full", 32'(b_full), 32'd1);
    strobe(1, 10, 10);
    check("b_adr_after", 32'(b_adr), 32'd1);
    check("b_full_after_next", 32'(b_full), 32'd0);

    repeat (5) @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
